line_buf_ctrl_1bit: RTL and testbench

//  Sequencer for the 1-bit 3x3 window datapath (two cascaded line FIFOs + window regs).

---
 rtl/line_buf_ctrl_1bit.sv | 140 ++++++++++++++
 tb/tb_line_buf_ctrl_1bit.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_ctrl_1bit.sv
// Sequencer for the 1-bit 3x3 window datapath: tracks pixel/line position, flushes and
// gates the two cascaded line FIFOs, and produces window-valid, border and status flags.
module line_buf_ctrl_1bit #(
  parameter logic [10:0] IMG_WIDTH  = 11'd1920,
  parameter logic [10:0] IMG_HEIGHT = 11'd1080,
  parameter logic [3:0]  FLUSH_CYC  = 4'd4
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        video_vs,
  input  logic        video_de,
  input  logic        fifo1_empty,
  output logic        fifo_rst,
  output logic        fifo1_wr_en,
  output logic        fifo2_wr_en,
  output logic        fifo_rd_en,
  output logic [10:0] x_cnt,
  output logic [10:0] y_cnt,
  output logic        win_de,
  output logic [3:0]  win_border,
  output logic        frame_done,
  output logic [1:0]  err_flags,
  output logic [2:0]  fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    PRIME = 3'd2,
    RUN   = 3'd3,
    LAST  = 3'd4
  } state_t;

  state_t      state;
  logic        vs_q;
  logic        de_q;
  logic [3:0]  flush_cnt;
  logic        de_p1;
  logic [10:0] x_p1;
  logic [10:0] y_p1;
  logic        err_underrun;
  logic        err_short;

  logic vs_rise;
  logic active;
  logic pix_end;
  logic short_end;
  logic line_end;

  assign vs_rise   = video_vs & ~vs_q;
  assign active    = (state == PRIME) || (state == RUN) || (state == LAST);
  assign pix_end   = active & video_de & (x_cnt == IMG_WIDTH - 11'd1);
  // A line that stops early still closes out so the frame keeps its line count.
  assign short_end = active & de_q & ~video_de & (x_cnt != 11'd0);
  assign line_end  = pix_end | short_end;

  // FIFO1 fills on every line except the last; reads start once line 0 is stored.
  assign fifo1_wr_en = video_de & ((state == PRIME) || (state == RUN));
  assign fifo_rd_en  = video_de & ((state == RUN) || (state == LAST));

  assign err_flags = {err_underrun, err_short};
  assign fsm_state = state;

  always_ff @(posedge video_clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      vs_q         <= 1'b0;
      de_q         <= 1'b0;
      flush_cnt    <= 4'd0;
      fifo_rst     <= 1'b0;
      fifo2_wr_en  <= 1'b0;
      x_cnt        <= 11'd0;
      y_cnt        <= 11'd0;
      de_p1        <= 1'b0;
      x_p1         <= 11'd0;
      y_p1         <= 11'd0;
      win_de       <= 1'b0;
      win_border   <= 4'd0;
      frame_done   <= 1'b0;
      err_underrun <= 1'b0;
      err_short    <= 1'b0;
    end else begin
      vs_q        <= video_vs;
      de_q        <= video_de;
      fifo2_wr_en <= fifo1_wr_en;
      frame_done  <= 1'b0;

      // Window centre lags the incoming pixel by two stages.
      de_p1      <= video_de & active;
      x_p1       <= x_cnt;
      y_p1       <= y_cnt;
      win_de     <= de_p1;
      win_border <= de_p1 ? {(y_p1 == 11'd0), (y_p1 == IMG_HEIGHT - 11'd1),
                             (x_p1 == 11'd0), (x_p1 == IMG_WIDTH - 11'd1)} : 4'd0;

      if (fifo_rd_en && fifo1_empty) err_underrun <= 1'b1;

      if (vs_rise) begin
        state        <= FLUSH;
        fifo_rst     <= 1'b1;
        flush_cnt    <= 4'd0;
        x_cnt        <= 11'd0;
        y_cnt        <= 11'd0;
        err_underrun <= 1'b0;
        err_short    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
          end
          FLUSH: begin
            if (flush_cnt == FLUSH_CYC - 4'd1) begin
              state    <= PRIME;
              fifo_rst <= 1'b0;
            end else begin
              flush_cnt <= flush_cnt + 4'd1;
            end
          end
          default: begin
            if (short_end) err_short <= 1'b1;
            if (line_end) begin
              x_cnt <= 11'd0;
              y_cnt <= (y_cnt == IMG_HEIGHT - 11'd1) ? 11'd0 : y_cnt + 11'd1;
              if (state == PRIME) begin
                state <= RUN;
              end else if (state == RUN) begin
                if (y_cnt == IMG_HEIGHT - 11'd2) state <= LAST;
              end else begin
                state      <= IDLE;
                frame_done <= 1'b1;
              end
            end else if (video_de) begin
              x_cnt <= x_cnt + 11'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_buf_ctrl_1bit.sv
// Randomised frame-level bench for line_buf_ctrl_1bit (8x4 image, 4-cycle flush):
// the driver pushes expected events with cycle stamps, a negedge monitor pops and compares.
module tb_line_buf_ctrl_1bit;
  localparam int W = 8;
  localparam int H = 4;
  localparam int NONE = 99;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        video_vs = 1'b0;
  logic        video_de = 1'b0;
  logic        fifo1_empty = 1'b0;
  logic        fifo_rst;
  logic        fifo1_wr_en;
  logic        fifo2_wr_en;
  logic        fifo_rd_en;
  logic [10:0] x_cnt;
  logic [10:0] y_cnt;
  logic        win_de;
  logic [3:0]  win_border;
  logic        frame_done;
  logic [1:0]  err_flags;
  logic [2:0]  fsm_state;

  line_buf_ctrl_1bit #(
    .IMG_WIDTH (11'd8),
    .IMG_HEIGHT(11'd4),
    .FLUSH_CYC (4'd4)
  ) dut (
    .video_clk  (clk),
    .rst_n      (rst_n),
    .video_vs   (video_vs),
    .video_de   (video_de),
    .fifo1_empty(fifo1_empty),
    .fifo_rst   (fifo_rst),
    .fifo1_wr_en(fifo1_wr_en),
    .fifo2_wr_en(fifo2_wr_en),
    .fifo_rd_en (fifo_rd_en),
    .x_cnt      (x_cnt),
    .y_cnt      (y_cnt),
    .win_de     (win_de),
    .win_border (win_border),
    .frame_done (frame_done),
    .err_flags  (err_flags),
    .fsm_state  (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  // scoreboard state
  int n_cmp  = 0;
  int n_fail = 0;
  logic [55:0] pix_q[$];   // {cycle, x, y, wr_en, rd_en}
  logic [35:0] win_q[$];   // {cycle, border}
  logic [31:0] f2_q[$];
  logic [31:0] fd_q[$];
  logic [31:0] rst_q[$];
  logic exp_short = 1'b0;
  logic exp_under = 1'b0;

  function automatic void check(input string name, input logic [63:0] got,
                                input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic void unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: output seen with nothing expected (cycle %0d)", name, cyc);
  endfunction

  // monitor
  always @(negedge clk) begin
    logic [55:0] pe;
    logic [35:0] we;
    logic [31:0] ce;
    if (fifo1_wr_en || fifo_rd_en) begin
      if (pix_q.size() == 0) unexpected("pixel_enables");
      else begin
        pe = pix_q.pop_front();
        check("pixel_cyc_x_y_wr_rd", {8'd0, cyc, x_cnt, y_cnt, fifo1_wr_en, fifo_rd_en},
              {8'd0, pe});
      end
    end
    if (fifo2_wr_en) begin
      if (f2_q.size() == 0) unexpected("fifo2_wr_en");
      else begin
        ce = f2_q.pop_front();
        check("fifo2_wr_cyc", {32'd0, cyc}, {32'd0, ce});
      end
    end
    if (win_de) begin
      if (win_q.size() == 0) unexpected("win_de");
      else begin
        we = win_q.pop_front();
        check("win_cyc_border", {28'd0, cyc, win_border}, {28'd0, we});
      end
    end else begin
      check("win_border_idle", {60'd0, win_border}, 64'd0);
    end
    if (frame_done) begin
      if (fd_q.size() == 0) unexpected("frame_done");
      else begin
        ce = fd_q.pop_front();
        check("frame_done_cyc", {32'd0, cyc}, {32'd0, ce});
      end
    end
    if (fifo_rst) begin
      check("flush_enables_off", {62'd0, fifo1_wr_en, fifo_rd_en}, 64'd0);
      if (rst_q.size() == 0) unexpected("fifo_rst");
      else begin
        ce = rst_q.pop_front();
        check("fifo_rst_cyc", {32'd0, cyc}, {32'd0, ce});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    video_de = 1'b0;
    repeat ($urandom_range(1, 4)) begin
      fifo1_empty = 1'($urandom_range(0, 1));
      tick();
    end
    fifo1_empty = 1'b0;
  endtask

  task automatic check_flags();
    check("err_flags", {62'd0, err_flags}, {62'd0, exp_under, exp_short});
  endtask

  // Raise vs in the current cycle; the flush occupies the next four cycles.
  task automatic start_frame();
    video_vs    = 1'b1;
    video_de    = 1'b0;
    fifo1_empty = 1'b0;
    for (int i = 1; i <= 4; i++) rst_q.push_back(cyc + 32'(i));
    exp_short = 1'b0;
    exp_under = 1'b0;
    tick();
    video_vs = 1'b0;
    repeat (4 + $urandom_range(0, 3)) tick();
  endtask

  task automatic send_line(input int l, input int len, input int empty_line);
    logic under_seen;
    logic [3:0] bord;
    under_seen = 1'b0;
    check_flags();
    for (int c = 0; c < len; c++) begin
      video_de    = 1'b1;
      fifo1_empty = (l == empty_line);
      pix_q.push_back({cyc, 11'(c), 11'(l), (l < H - 1), (l > 0)});
      if (l < H - 1) f2_q.push_back(cyc + 32'd1);
      bord = {(l == 0), (l == H - 1), (c == 0), (c == W - 1)};
      win_q.push_back({cyc + 32'd2, bord});
      if (l == H - 1 && c == W - 1) fd_q.push_back(cyc + 32'd1);
      if (fifo1_empty && l > 0) under_seen = 1'b1;
      tick();
    end
    video_de    = 1'b0;
    fifo1_empty = 1'b0;
    if (len < W) exp_short = 1'b1;
    if (under_seen) exp_under = 1'b1;
  endtask

  // A frame; abort_line restarts the frame with vs after abort_len pixels of that line.
  task automatic send_frame(input logic do_start, input int cut_line, input int cut_len,
                            input int empty_line, input int abort_line, input int abort_len);
    if (do_start) start_frame();
    for (int l = 0; l < H; l++) begin
      if (l == abort_line) begin
        send_line(l, abort_len, empty_line);
        start_frame();
        return;
      end
      send_line(l, (l == cut_line) ? cut_len : W, empty_line);
      gap();
    end
    repeat (3) tick();
    check_flags();
  endtask

  task automatic idle_burst();
    for (int c = 0; c < W; c++) begin
      video_de = 1'b1;
      tick();
    end
    video_de = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_xy"}, {42'd0, x_cnt, y_cnt}, 64'd0);
    check({tag, "_rst_done_win"}, {61'd0, fifo_rst, frame_done, win_de}, 64'd0);
    check({tag, "_fifo2"}, {63'd0, fifo2_wr_en}, 64'd0);
    check({tag, "_err"}, {62'd0, err_flags}, 64'd0);
  endtask

  initial begin
    int cl;
    int el;
    repeat (3) tick();
    rst_n = 1'b1;
    check_quiet("reset");
    check("reset_enables", {62'd0, fifo1_wr_en, fifo_rd_en}, 64'd0);

    // de without a frame start must not enable anything
    idle_burst();

    // clean frame, then the cut-line / underrun frame
    send_frame(1'b1, NONE, W, NONE, NONE, 0);
    send_frame(1'b1, 1, 5, 2, NONE, 0);

    // short line, then vs in the middle of line 2; the restarted frame runs clean
    send_frame(1'b1, 1, $urandom_range(1, W - 1), NONE, 2, $urandom_range(1, W - 1));
    check_flags();
    check("abort_xy", {42'd0, x_cnt, y_cnt}, 64'd0);
    send_frame(1'b0, NONE, W, NONE, NONE, 0);

    // randomised frames
    for (int k = 0; k < 6; k++) begin
      cl = $urandom_range(0, 3);
      el = $urandom_range(0, 4);
      send_frame(1'b1, (cl == 3) ? NONE : cl, $urandom_range(1, W - 1),
                 (el == 4) ? NONE : el, NONE, 0);
    end

    // reset in the gap after line 1, then no restart until a fresh vs
    start_frame();
    send_line(0, W, NONE);
    gap();
    send_line(1, W, NONE);
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check_quiet("midreset");
    idle_burst();
    send_frame(1'b1, NONE, W, 1, NONE, 0);

    repeat (10) tick();
    check("left_pix_q", 64'(pix_q.size()), 64'd0);
    check("left_win_q", 64'(win_q.size()), 64'd0);
    check("left_f2_q", 64'(f2_q.size()), 64'd0);
    check("left_fd_q", 64'(fd_q.size()), 64'd0);
    check("left_rst_q", 64'(rst_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
